// File: rtl/gate_id_pkg.sv
// Shared encodings for the gate identifier: sel codes, expected response
// signatures, FSM state type and the signature decoder.
package gate_id_pkg;

  localparam logic [1:0] SEL_NOT = 2'b00;
  localparam logic [1:0] SEL_AND = 2'b01;
  localparam logic [1:0] SEL_OR  = 2'b10;
  localparam logic [1:0] SEL_XOR = 2'b11;

  // Bit k of a signature is Y observed with {A,B} = k.
  localparam logic [3:0] SIG_NOT = 4'b0011;
  localparam logic [3:0] SIG_AND = 4'b1000;
  localparam logic [3:0] SIG_OR  = 4'b1110;
  localparam logic [3:0] SIG_XOR = 4'b0110;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DECODE} state_t;

  typedef struct packed {
    logic [1:0] sel;
    logic       error;
  } decode_t;

  function automatic decode_t decode_sig(input logic [3:0] sig);
    decode_t d;
    d.sel   = SEL_NOT;
    d.error = 1'b0;
    case (sig)
      SIG_NOT: d.sel = SEL_NOT;
      SIG_AND: d.sel = SEL_AND;
      SIG_OR:  d.sel = SEL_OR;
      SIG_XOR: d.sel = SEL_XOR;
      default: d.error = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gate_id_settle_timer.sv
// Per-vector settle counter: loads a value, counts down to zero and flags
// expiry while the count sits at zero.
module gate_id_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_identifier.sv
// Identifies an unknown 2-input gate by sweeping {A,B} and decoding Y.
// Define GATE_ID_SIG_OUT_EN to expose the captured signature on sig_out.
module gate_identifier
  import gate_id_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Y,
  output logic [1:0] sel,
  output logic       valid,
  output logic       busy,
  output logic       error
`ifdef GATE_ID_SIG_OUT_EN
  ,
  output logic [3:0] sig_out
`endif
);

  // Each vector spends SETTLE_CYCLES cycles in DRIVE plus one SAMPLE cycle,
  // so DRIVE is skipped entirely when there is nothing to settle.
  localparam logic [3:0] LOAD_VALUE = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam bit         SKIP_DRIVE = (SETTLE_CYCLES == 0);

  state_t     state;
  state_t     next_state;
  logic       armed;
  logic [1:0] idx;
  logic [3:0] sig;
  logic [3:0] sig_next;
  logic       timer_load;
  logic       timer_count;
  logic       timer_expired;
  decode_t    decoded;

  gate_id_settle_timer #(.WIDTH(4)) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (LOAD_VALUE),
    .count_en   (timer_count),
    .expired    (timer_expired)
  );

  always_comb begin
    sig_next      = sig;
    sig_next[idx] = Y;
  end

  assign decoded = decode_sig(sig_next);

  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_count = 1'b0;
    case (state)
      IDLE: begin
        if (start && armed) begin
          timer_load = 1'b1;
          next_state = SKIP_DRIVE ? SAMPLE : DRIVE;
        end
      end
      DRIVE: begin
        if (timer_expired) begin
          next_state = SAMPLE;
        end else begin
          timer_count = 1'b1;
        end
      end
      SAMPLE: begin
        if (idx == 2'd3) begin
          next_state = DECODE;
        end else begin
          timer_load = 1'b1;
          next_state = SKIP_DRIVE ? SAMPLE : DRIVE;
        end
      end
      DECODE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // armed blocks start for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      idx   <= 2'd0;
      sig   <= 4'd0;
      sel   <= SEL_NOT;
      error <= 1'b0;
`ifdef GATE_ID_SIG_OUT_EN
      sig_out <= 4'd0;
`endif
    end else begin
      state <= next_state;
      armed <= 1'b1;
      if (state == SAMPLE) begin
        sig <= sig_next;
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          sel   <= decoded.sel;
          error <= decoded.error;
`ifdef GATE_ID_SIG_OUT_EN
          sig_out <= sig_next;
`endif
        end
      end
    end
  end

  assign A     = ((state == DRIVE) || (state == SAMPLE)) && idx[1];
  assign B     = ((state == DRIVE) || (state == SAMPLE)) && idx[0];
  assign valid = (state == DECODE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier: one instance with SETTLE_CYCLES=2 and
// one with SETTLE_CYCLES=0, each driven by a behavioural gate model.
module tb_gate_identifier;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic a0, b0, y0, valid0, busy0, error0;
  logic a1, b1, y1, valid1, busy1, error1;
  logic [1:0] sel0, sel1;
  logic [3:0] sig_out0, sig_out1;
  int mode0 = 1;
  int mode1 = 3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // mode: 0 NOT(A), 1 AND, 2 OR, 3 XOR, anything else Y stuck at 1
  function automatic logic gate_model(input int mode, input logic a, input logic b);
    case (mode)
      0:       return ~a;
      1:       return a & b;
      2:       return a | b;
      3:       return a ^ b;
      default: return 1'b1;
    endcase
  endfunction

  assign y0 = gate_model(mode0, a0, b0);
  assign y1 = gate_model(mode1, a1, b1);

`ifndef GATE_ID_SIG_OUT_EN
  assign sig_out0 = 4'd0;
  assign sig_out1 = 4'd0;
`endif

  gate_identifier #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0), .Y(y0),
    .sel(sel0), .valid(valid0), .busy(busy0), .error(error0)
`ifdef GATE_ID_SIG_OUT_EN
    , .sig_out(sig_out0)
`endif
  );

  gate_identifier #(.SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Y(y1),
    .sel(sel1), .valid(valid1), .busy(busy1), .error(error1)
`ifdef GATE_ID_SIG_OUT_EN
    , .sig_out(sig_out1)
`endif
  );

  // Pulses start on one instance and watches it until valid (bounded);
  // lat is the valid cycle relative to the start cycle T, -1 on timeout.
  task automatic run_dut(input int which, input int repulse_at, output int lat,
                         output bit busy_ok, output bit ab_ok, output logic [1:0] s,
                         output logic e, output logic [3:0] so);
    int hold;
    logic a, b, v, bz;
    hold = (which == 0) ? 3 : 1;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    lat = -1; busy_ok = 1'b1; ab_ok = 1'b1; s = 2'b00; e = 1'b0; so = 4'd0;
    for (int c = 1; c <= 40; c++) begin
      a  = (which == 0) ? a0 : a1;
      b  = (which == 0) ? b0 : b1;
      v  = (which == 0) ? valid0 : valid1;
      bz = (which == 0) ? busy0 : busy1;
      if (!bz) busy_ok = 1'b0;
      if (v) begin
        lat = c;
        s   = (which == 0) ? sel0 : sel1;
        e   = (which == 0) ? error0 : error1;
        so  = (which == 0) ? sig_out0 : sig_out1;
        if (a || b) ab_ok = 1'b0;
        break;
      end
      if (c <= 4 * hold && {a, b} != 2'((c - 1) / hold)) ab_ok = 1'b0;
      if (which == 0) start0 = (c == repulse_at); else start1 = (c == repulse_at);
      @(negedge clk);
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({a0, b0} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ab: got %b expected 00", {a0, b0}); end
    checks++; if ({valid0, busy0, error0} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {valid0, busy0, error0}); end
    checks++; if (sel0 !== 2'b00) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 00", sel0); end
    rst_n = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL start_after_release: busy got %b expected 0", busy0); end
    @(negedge clk);
  endtask

  task automatic test_and();
    int lat; bit bok, abok; logic [1:0] s; logic e; logic [3:0] so;
    mode0 = 1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL and_idle_busy: got %b expected 0", busy0); end
    run_dut(0, 0, lat, bok, abok, s, e, so);
    checks++; if (lat != 13) begin errors++; $display("[TB] FAIL and_latency: got %0d expected 13", lat); end
    checks++; if (!bok) begin errors++; $display("[TB] FAIL and_busy_window: got low expected high T+1..T+13"); end
    checks++; if (!abok) begin errors++; $display("[TB] FAIL and_vectors: got wrong A/B sequence expected 00,01,10,11 then 00"); end
    checks++; if (s !== 2'b01 || e !== 1'b0) begin errors++; $display("[TB] FAIL and_result: got sel=%b err=%b expected sel=01 err=0", s, e); end
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL and_busy_after: got %b expected 0", busy0); end
  endtask

  task automatic test_gate(input int mode, input logic [1:0] exp_sel, input logic exp_err,
                           input logic [3:0] exp_sig);
    int lat; bit bok, abok; logic [1:0] s; logic e; logic [3:0] so;
    mode0 = mode;
    run_dut(0, 0, lat, bok, abok, s, e, so);
    checks++; if (lat != 13) begin errors++; $display("[TB] FAIL gate%0d_latency: got %0d expected 13", mode, lat); end
    checks++; if (s !== exp_sel || e !== exp_err) begin errors++; $display("[TB] FAIL gate%0d_result: got sel=%b err=%b expected sel=%b err=%b", mode, s, e, exp_sel, exp_err); end
`ifdef GATE_ID_SIG_OUT_EN
    checks++; if (so !== exp_sig) begin errors++; $display("[TB] FAIL gate%0d_sig_out: got %b expected %b", mode, so, exp_sig); end
`else
    if (exp_sig === 4'bxxxx) $display("[TB] unexpected signature argument");
`endif
    repeat (3) @(negedge clk);
    checks++; if (sel0 !== exp_sel || error0 !== exp_err) begin errors++; $display("[TB] FAIL gate%0d_hold: got sel=%b err=%b expected sel=%b err=%b", mode, sel0, error0, exp_sel, exp_err); end
  endtask

  task automatic test_reset_midrun();
    int lat; bit bok, abok; logic [1:0] s; logic e; logic [3:0] so;
    bit saw_valid;
    mode0 = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if ({a0, b0} !== 2'b10) begin errors++; $display("[TB] FAIL midrun_vector2: got %b expected 10", {a0, b0}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({a0, b0, valid0, busy0, error0} !== 5'b00000) begin errors++; $display("[TB] FAIL midrun_async_flags: got %b expected 00000", {a0, b0, valid0, busy0, error0}); end
    checks++; if (sel0 !== 2'b00) begin errors++; $display("[TB] FAIL midrun_async_sel: got %b expected 00", sel0); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (valid0 || busy0) saw_valid = 1'b1;
    end
    checks++; if (saw_valid) begin errors++; $display("[TB] FAIL midrun_no_valid: got activity expected idle"); end
    run_dut(0, 0, lat, bok, abok, s, e, so);
    checks++; if (lat != 13 || s !== 2'b01 || e !== 1'b0 || !abok) begin errors++; $display("[TB] FAIL midrun_rerun: got lat=%0d sel=%b err=%b expected lat=13 sel=01 err=0", lat, s, e); end
    @(negedge clk);
  endtask

  task automatic test_busy_repulse();
    int lat; bit bok, abok; logic [1:0] s; logic e; logic [3:0] so;
    int busy_seen;
    mode0 = 2;
    run_dut(0, 5, lat, bok, abok, s, e, so);
    checks++; if (lat != 13 || s !== 2'b10) begin errors++; $display("[TB] FAIL repulse_run: got lat=%0d sel=%b expected lat=13 sel=10", lat, s); end
    busy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy0) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin errors++; $display("[TB] FAIL repulse_ignored: got %0d busy cycles expected 0", busy_seen); end
  endtask

  task automatic test_back_to_back();
    int first_v, second_v, idle_cycles;
    mode0 = 3;
    first_v = -1; second_v = -1; idle_cycles = 0;
    start0 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 27; c++) begin
      if (valid0) begin
        if (first_v < 0) first_v = c; else if (second_v < 0) second_v = c;
      end
      if (!busy0) idle_cycles++;
      if (c == 27) start0 = 1'b0;
      @(negedge clk);
    end
    start0 = 1'b0;
    checks++; if (first_v != 13 || second_v != 27) begin errors++; $display("[TB] FAIL b2b_valid_cycles: got %0d,%0d expected 13,27", first_v, second_v); end
    checks++; if (idle_cycles != 1) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %0d expected 1", idle_cycles); end
    checks++; if (busy0 !== 1'b0 || sel0 !== 2'b11) begin errors++; $display("[TB] FAIL b2b_end: got busy=%b sel=%b expected busy=0 sel=11", busy0, sel0); end
  endtask

  task automatic test_zero_settle();
    int lat; bit bok, abok; logic [1:0] s; logic e; logic [3:0] so;
    mode1 = 3;
    run_dut(1, 0, lat, bok, abok, s, e, so);
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 5", lat); end
    checks++; if (s !== 2'b11 || e !== 1'b0) begin errors++; $display("[TB] FAIL zero_result: got sel=%b err=%b expected sel=11 err=0", s, e); end
    checks++; if (!bok || !abok) begin errors++; $display("[TB] FAIL zero_sequence: got busy_ok=%0d ab_ok=%0d expected 1,1", bok, abok); end
`ifdef GATE_ID_SIG_OUT_EN
    checks++; if (so !== 4'b0110) begin errors++; $display("[TB] FAIL zero_sig_out: got %b expected 0110", so); end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_and();
    test_gate(0, 2'b00, 1'b0, 4'b0011);
    test_gate(2, 2'b10, 1'b0, 4'b1110);
    test_gate(4, 2'b00, 1'b1, 4'b1111);
    test_gate(3, 2'b11, 1'b0, 4'b0110);
    test_reset_midrun();
    test_busy_repulse();
    test_back_to_back();
    test_zero_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
